// File: rtl/hdc_argmin_stream_pkg.sv
// hdc_argmin_stream_pkg: shared types, defaults and FSM states for the argmin reducer
package hdc_argmin_stream_pkg;
  localparam int DW_DEF = 32;
  localparam int CLSW_DEF = 16;
  localparam int NCLS_DEF = 10;
  typedef logic [DW_DEF-1:0] dist_t;
  typedef logic [CLSW_DEF-1:0] cls_t;
  localparam dist_t DIST_MAX = '1;
  typedef enum logic [1:0] {INIT, COLLECT, DONE} state_t;
endpackage

// File: rtl/hdc_argmin_stream_if.sv
// hdc_argmin_stream_if: distance input stream and result output stream
interface hdc_argmin_stream_if import hdc_argmin_stream_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CLSW = CLSW_DEF
);
  logic s_valid;
  logic s_ready;
  logic [DW-1:0] s_dist;
  logic m_valid;
  logic m_ready;
  logic [CLSW-1:0] m_cls;
  logic [DW-1:0] m_dist;
  logic [DW-1:0] m_margin;
  modport master (output s_valid, s_dist, m_ready, input s_ready, m_valid, m_cls, m_dist, m_margin);
  modport slave (input s_valid, s_dist, m_ready, output s_ready, m_valid, m_cls, m_dist, m_margin);
endinterface

// File: rtl/hdc_argmin_stream_update.sv
// argmin_update: one compare step of the running minimum / runner-up tracker
module argmin_update #(
  parameter int DW = 32,
  parameter int CLSW = 16
) (
  input  logic [DW-1:0]   best,
  input  logic [DW-1:0]   second,
  input  logic [CLSW-1:0] cls,
  input  logic [CLSW-1:0] idx,
  input  logic [DW-1:0]   s_dist,
  input  logic            first,
  output logic [DW-1:0]   nbest,
  output logic [DW-1:0]   nsecond,
  output logic [CLSW-1:0] ncls
);
  logic lt_best, lt_sec;
  always_comb begin
    lt_best = s_dist < best;
    lt_sec = s_dist < second;
    nbest = (first || lt_best) ? s_dist : best;
    nsecond = first ? '1 : lt_best ? best : lt_sec ? s_dist : second;
    ncls = first ? '0 : lt_best ? idx : cls;
  end
endmodule

// File: rtl/hdc_argmin_stream.sv
// hdc_argmin_stream: sequential argmin over NCLS streamed class distances with margin
module hdc_argmin_stream import hdc_argmin_stream_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CLSW = CLSW_DEF,
  parameter int NCLS = NCLS_DEF
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  hdc_argmin_stream_if.slave io
);
  localparam int IW = (NCLS > 1) ? $clog2(NCLS) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic [DW-1:0] best, second, nbest, nsecond, m_dist, m_margin;
  logic [CLSW-1:0] cls, ncls, m_cls;
  logic last;
  assign last = idx == IW'(NCLS - 1);
  argmin_update #(.DW(DW), .CLSW(CLSW)) u_upd (
    .best(best), .second(second), .cls(cls), .idx(CLSW'(idx)), .s_dist(io.s_dist),
    .first(idx == '0), .nbest(nbest), .nsecond(nsecond), .ncls(ncls)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      idx <= '0;
      best <= '0;
      second <= '0;
      cls <= '0;
      m_cls <= '0;
      m_dist <= '0;
      m_margin <= '0;
    end else if (state == INIT) state <= COLLECT;
    else if (state == DONE) begin
      if (clear || io.m_ready) state <= COLLECT;
    end else if (clear) idx <= '0;
    else if (io.s_valid) begin
      best <= nbest;
      second <= nsecond;
      cls <= ncls;
      if (last) begin
        idx <= '0;
        state <= DONE;
        m_cls <= ncls;
        m_dist <= nbest;
        m_margin <= nsecond - nbest;
      end else idx <= idx + IW'(1);
    end
  assign io.s_ready = state == COLLECT;
  assign io.m_valid = state == DONE;
  assign io.m_cls = m_cls;
  assign io.m_dist = m_dist;
  assign io.m_margin = m_margin;
endmodule

// File: tb/tb_hdc_argmin_stream.sv
// tb_hdc_argmin_stream: randomized and directed checks against an argmin reference model
module tb_hdc_argmin_stream;
  typedef logic [7:0] q_t [4];
  logic clk = 0, rst_n = 0, clear = 0;
  int total = 0, bad = 0;
  hdc_argmin_stream_if #(.DW(8), .CLSW(16)) io ();
  hdc_argmin_stream #(.DW(8), .CLSW(16), .NCLS(4)) dut (.clk(clk), .rst_n(rst_n), .clear(clear), .io(io.slave));
  always #5 clk = ~clk;

  function automatic void model(input q_t v, output logic [15:0] c, output logic [7:0] d, output logic [7:0] m);
    int w = 0;
    logic [7:0] sec = 8'hff;
    for (int i = 1; i < 4; i++) if (v[i] < v[w]) w = i;
    for (int i = 0; i < 4; i++) if (i != w && v[i] < sec) sec = v[i];
    c = 16'(w);
    d = v[w];
    m = sec - v[w];
  endfunction

  task automatic drive_beats(input q_t v, input int gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) begin
        io.s_valid = 0;
        io.s_dist = 8'($urandom);
        @(negedge clk);
      end
      io.s_valid = 1;
      io.s_dist = v[i];
      @(negedge clk);
    end
    io.s_valid = 0;
  endtask

  task automatic test_reset;
    io.s_valid = 0; io.s_dist = 0; io.m_ready = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if (io.s_ready !== 0 || io.m_valid !== 0 || io.m_cls !== 0 || io.m_dist !== 0 || io.m_margin !== 0) begin
      bad++; $display("FAIL reset_vals: rdy=%b vld=%b cls=%0d dist=%0d mar=%0d want all 0", io.s_ready, io.m_valid, io.m_cls, io.m_dist, io.m_margin);
    end
    rst_n = 1;
    #1 total++;
    if (io.s_ready !== 0) begin bad++; $display("FAIL init_cycle: s_ready=%b want 0", io.s_ready); end
    @(negedge clk);
    total++;
    if (io.s_ready !== 1) begin bad++; $display("FAIL after_init: s_ready=%b want 1", io.s_ready); end
  endtask

  task automatic test_query(input string name, input q_t v, input int gaps);
    logic [15:0] c; logic [7:0] d, m;
    model(v, c, d, m);
    io.m_ready = 1;
    drive_beats(v, gaps);
    total++;
    if (io.m_valid !== 1 || io.m_cls !== c || io.m_dist !== d || io.m_margin !== m) begin
      bad++; $display("FAIL %s: vld=%b cls=%0d dist=%0d mar=%0d want 1/%0d/%0d/%0d", name, io.m_valid, io.m_cls, io.m_dist, io.m_margin, c, d, m);
    end
    @(negedge clk);
    total++;
    if (io.m_valid !== 0 || io.s_ready !== 1) begin
      bad++; $display("FAIL %s_oneshot: vld=%b rdy=%b want 0/1", name, io.m_valid, io.s_ready);
    end
  endtask

  task automatic test_backpressure(input q_t v, input int hold);
    logic [15:0] c; logic [7:0] d, m;
    model(v, c, d, m);
    io.m_ready = 0;
    drive_beats(v, 0);
    repeat (hold) begin
      total++;
      if (io.m_valid !== 1 || io.s_ready !== 0 || io.m_cls !== c || io.m_dist !== d || io.m_margin !== m) begin
        bad++; $display("FAIL hold: vld=%b rdy=%b cls=%0d dist=%0d mar=%0d want 1/0/%0d/%0d/%0d", io.m_valid, io.s_ready, io.m_cls, io.m_dist, io.m_margin, c, d, m);
      end
      io.s_valid = 1;
      io.s_dist = 8'($urandom);
      @(negedge clk);
    end
    io.s_valid = 0;
    io.m_ready = 1;
    @(negedge clk);
    total++;
    if (io.m_valid !== 0 || io.s_ready !== 1) begin
      bad++; $display("FAIL release: vld=%b rdy=%b want 0/1", io.m_valid, io.s_ready);
    end
  endtask

  task automatic test_clear;
    io.m_ready = 1;
    drive_beats('{8'd1, 8'd2, 8'd0, 8'd0}, 0);
    total++;
    if (io.m_valid !== 1) begin bad++; $display("FAIL clr_setup: vld=%b want 1", io.m_valid); end
    @(negedge clk);
    io.s_valid = 1; io.s_dist = 8'd1;
    @(negedge clk);
    io.s_dist = 8'd2;
    @(negedge clk);
    io.s_dist = 8'd0; clear = 1;
    @(negedge clk);
    clear = 0; io.s_valid = 0;
    total++;
    if (io.m_valid !== 0 || io.s_ready !== 1) begin bad++; $display("FAIL clr_mid: vld=%b rdy=%b want 0/1", io.m_valid, io.s_ready); end
    test_query("clr_query", '{8'd100, 8'd90, 8'd80, 8'd255}, 0);
  endtask

  task automatic test_clear_done;
    io.m_ready = 0;
    drive_beats('{8'd5, 8'd6, 8'd7, 8'd8}, 0);
    clear = 1;
    @(negedge clk);
    clear = 0;
    total++;
    if (io.m_valid !== 0 || io.s_ready !== 1) begin bad++; $display("FAIL clr_done: vld=%b rdy=%b want 0/1", io.m_valid, io.s_ready); end
    test_query("after_clr_done", '{8'd9, 8'd3, 8'd3, 8'd1}, 1);
  endtask

  task automatic test_reset_mid;
    io.m_ready = 1;
    io.s_valid = 1; io.s_dist = 8'd1;
    @(negedge clk);
    io.s_dist = 8'd2;
    @(negedge clk);
    io.s_valid = 0;
    rst_n = 0;
    @(negedge clk);
    total++;
    if (io.m_valid !== 0 || io.s_ready !== 0) begin bad++; $display("FAIL rst_mid: vld=%b rdy=%b want 0/0", io.m_valid, io.s_ready); end
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (io.m_valid !== 0) begin bad++; $display("FAIL rst_no_partial: vld=%b want 0", io.m_valid); end
    end
    test_query("rst_query", '{8'd6, 8'd4, 8'd8, 8'd5}, 3);
  endtask

  task automatic test_random(input int n);
    q_t v;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) v[i] = (k % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if (k % 3 == 0) test_backpressure(v, $urandom_range(1, 4));
      else test_query("random", v, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset;
    test_query("descending", '{8'd9, 8'd7, 8'd5, 8'd3}, 0);
    test_query("tie", '{8'd50, 8'd20, 8'd35, 8'd20}, 0);
    test_query("all_ones", '{8'd255, 8'd255, 8'd255, 8'd255}, 0);
    test_backpressure('{8'd40, 8'd30, 8'd20, 8'd10}, 5);
    test_clear;
    test_clear_done;
    test_reset_mid;
    test_random(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end
endmodule
